// File: rtl/qpsk_pkg.sv
// Shared types, constants and the Gray QPSK mapping for the QPSK TX/RX chain.
package qpsk_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPreamble = 2'd1,
        StData     = 2'd2
    } state_e;

    // Preamble alternates between opposite corners of the constellation.
    localparam logic [1:0] PreDibitEven = 2'b00;
    localparam logic [1:0] PreDibitOdd  = 2'b11;

    localparam int unsigned DibitsPerWord = 16;

    // Gray map: bit1 selects the sign of I, bit0 the sign of Q; result is {I, Q}.
    function automatic logic [31:0] dibit_to_iq(input logic [1:0] dibit, input logic [15:0] amp);
        logic [15:0] pos;
        logic [15:0] neg;
        logic [15:0] i_val;
        logic [15:0] q_val;
        pos   = amp;
        neg   = ~amp + 16'd1;
        i_val = dibit[1] ? neg : pos;
        q_val = dibit[0] ? neg : pos;
        return {i_val, q_val};
    endfunction

endpackage

// File: rtl/qpsk_symbol_mapper.sv
// Combinational dibit + amplitude to {I, Q} sample mapper.
module qpsk_symbol_mapper (
    input  logic [1:0]  dibit,
    input  logic [15:0] amp,
    output logic [31:0] iq
);
    import qpsk_pkg::*;

    // Pure table lookup; the function is shared with receiver-side models.
    always_comb begin
        iq = dibit_to_iq(dibit, amp);
    end

endmodule

// File: rtl/qpsk_tx_mod.sv
// QPSK transmit modulator: preamble insertion, dibit mapping and SPS sample hold.
module qpsk_tx_mod #(
    parameter int unsigned SPS      = 16,
    parameter int unsigned PRE_SYMS = 32
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        clear,
    input  logic [15:0] amp,
    input  logic [31:0] s_tdata,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready
);
    import qpsk_pkg::*;

    localparam int unsigned SampW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int unsigned PreW  = (PRE_SYMS > 1) ? $clog2(PRE_SYMS) : 1;
    localparam logic [SampW-1:0] SampLast = SampW'(SPS - 1);
    localparam logic [PreW-1:0]  PreLast  = PreW'((PRE_SYMS > 0) ? PRE_SYMS - 1 : 0);

    state_e            state_q, state_d;
    logic [SampW-1:0]  samp_cnt_q, samp_cnt_d;
    logic [3:0]        sym_cnt_q, sym_cnt_d;
    logic [PreW-1:0]   pre_cnt_q, pre_cnt_d;
    logic [31:0]       word_q, word_d;
    logic              word_last_q, word_last_d;
    logic              word_valid_q, word_valid_d;
    logic [15:0]       amp_q, amp_d;

    logic        hs;
    logic        samp_last;
    logic        sym_last;
    logic        consume;
    logic        load;
    logic [4:0]  bit_lo;
    logic [1:0]  dibit;
    logic [31:0] iq;

    // Handshake decode; s_tready depends on m_tready so words stream without gaps.
    always_comb begin
        m_tvalid  = (state_q == StPreamble) || ((state_q == StData) && word_valid_q);
        hs        = m_tvalid && m_tready;
        samp_last = (samp_cnt_q == SampLast);
        sym_last  = (sym_cnt_q == 4'd15);
        consume   = (state_q == StData) && word_valid_q && hs && sym_last && samp_last;
        s_tready  = !word_valid_q || consume;
        load      = s_tvalid && s_tready;
        m_tlast   = (state_q == StData) && word_last_q && sym_last && samp_last;
    end

    // Dibit selection: alternating corners in preamble, MSB-first dibits in data.
    always_comb begin
        bit_lo = 5'd30 - {sym_cnt_q, 1'b0};
        dibit  = word_q[bit_lo +: 2];
        if (state_q == StPreamble) begin
            dibit = pre_cnt_q[0] ? PreDibitOdd : PreDibitEven;
        end
    end

    qpsk_symbol_mapper u_mapper (
        .dibit (dibit),
        .amp   (amp_q),
        .iq    (iq)
    );

    // Output data is zeroed whenever no sample is offered.
    always_comb begin
        m_tdata = m_tvalid ? iq : 32'd0;
    end

    // Holding register: load wins over consume so back-to-back words keep word_valid high.
    always_comb begin
        word_d       = word_q;
        word_last_d  = word_last_q;
        word_valid_d = word_valid_q;
        if (load) begin
            word_d       = s_tdata;
            word_last_d  = s_tlast;
            word_valid_d = 1'b1;
        end else if (consume) begin
            word_valid_d = 1'b0;
        end
    end

    // FSM and counters; counters only move on an output handshake.
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        pre_cnt_d  = pre_cnt_q;
        amp_d      = amp_q;
        case (state_q)
            StIdle: begin
                if (word_valid_q) begin
                    amp_d      = amp;
                    samp_cnt_d = '0;
                    sym_cnt_d  = '0;
                    pre_cnt_d  = '0;
                    state_d    = (PRE_SYMS == 0) ? StData : StPreamble;
                end
            end
            StPreamble: begin
                if (hs) begin
                    if (samp_last) begin
                        samp_cnt_d = '0;
                        if (pre_cnt_q == PreLast) begin
                            pre_cnt_d = '0;
                            state_d   = StData;
                        end else begin
                            pre_cnt_d = pre_cnt_q + 1'b1;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (hs) begin
                    if (samp_last) begin
                        samp_cnt_d = '0;
                        sym_cnt_d  = sym_cnt_q + 4'd1;
                        if (sym_last && word_last_q) begin
                            state_d = StIdle;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; clear flushes exactly like reset, including any held word.
    always_ff @(posedge ce_clk or negedge ce_rst) begin
        if (!ce_rst) begin
            state_q      <= StIdle;
            samp_cnt_q   <= '0;
            sym_cnt_q    <= '0;
            pre_cnt_q    <= '0;
            word_q       <= '0;
            word_last_q  <= 1'b0;
            word_valid_q <= 1'b0;
            amp_q        <= '0;
        end else if (clear) begin
            state_q      <= StIdle;
            samp_cnt_q   <= '0;
            sym_cnt_q    <= '0;
            pre_cnt_q    <= '0;
            word_q       <= '0;
            word_last_q  <= 1'b0;
            word_valid_q <= 1'b0;
            amp_q        <= '0;
        end else begin
            state_q      <= state_d;
            samp_cnt_q   <= samp_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            word_q       <= word_d;
            word_last_q  <= word_last_d;
            word_valid_q <= word_valid_d;
            amp_q        <= amp_d;
        end
    end

endmodule

// File: tb/tb_qpsk_tx_mod.sv
// Self-checking bench for qpsk_tx_mod: two instances (with and without preamble),
// randomized words/ready against a packet-level reference model.
module tb_qpsk_tx_mod;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] amp = 16'h2D41;
    logic [31:0] s_tdata = 32'd0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        m_tready = 1'b0;
    logic        sel = 1'b0;

    logic        a_s_tready, a_m_tlast, a_m_tvalid;
    logic [31:0] a_m_tdata;
    logic        b_s_tready, b_m_tlast, b_m_tvalid;
    logic [31:0] b_m_tdata;
    logic        a_s_tvalid, b_s_tvalid;
    logic        obs_valid, obs_last, obs_s_tready;
    logic [31:0] obs_data;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign a_s_tvalid   = s_tvalid & ~sel;
    assign b_s_tvalid   = s_tvalid & sel;
    assign obs_valid    = sel ? b_m_tvalid : a_m_tvalid;
    assign obs_last     = sel ? b_m_tlast : a_m_tlast;
    assign obs_data     = sel ? b_m_tdata : a_m_tdata;
    assign obs_s_tready = sel ? b_s_tready : a_s_tready;

    qpsk_tx_mod #(.SPS(4), .PRE_SYMS(2)) dut_a (
        .ce_clk   (clk),
        .ce_rst   (rst_n),
        .clear    (clear),
        .amp      (amp),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .s_tvalid (a_s_tvalid),
        .s_tready (a_s_tready),
        .m_tdata  (a_m_tdata),
        .m_tlast  (a_m_tlast),
        .m_tvalid (a_m_tvalid),
        .m_tready (m_tready)
    );

    qpsk_tx_mod #(.SPS(16), .PRE_SYMS(0)) dut_b (
        .ce_clk   (clk),
        .ce_rst   (rst_n),
        .clear    (clear),
        .amp      (amp),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .s_tvalid (b_s_tvalid),
        .s_tready (b_s_tready),
        .m_tdata  (b_m_tdata),
        .m_tlast  (b_m_tlast),
        .m_tvalid (b_m_tvalid),
        .m_tready (m_tready)
    );

    logic [31:0] words[$];
    logic [31:0] exp_data[$];
    logic        exp_last[$];
    logic [31:0] got_data[$];
    logic        got_last[$];
    int acc_cyc, first_vld_cyc, last_hs_cyc, stall_err;
    bit timed_out;

    // Reference: {I,Q} from sign rules with plain integer arithmetic.
    function automatic logic [31:0] ref_iq(input int d, input int a);
        int n;
        logic [15:0] i16;
        logic [15:0] q16;
        n   = (65536 - a) % 65536;
        i16 = 16'((d >= 2) ? n : a);
        q16 = 16'((d % 2 == 1) ? n : a);
        return {i16, q16};
    endfunction

    // Whole-packet expected sample list for the current words queue.
    task automatic build_exp(input int a, input int pre, input int sps);
        int d;
        exp_data.delete();
        exp_last.delete();
        for (int j = 0; j < pre; j++) begin
            d = (j % 2 == 1) ? 3 : 0;
            for (int s = 0; s < sps; s++) begin
                exp_data.push_back(ref_iq(d, a));
                exp_last.push_back(1'b0);
            end
        end
        for (int w = 0; w < words.size(); w++) begin
            for (int k = 0; k < 16; k++) begin
                d = int'((words[w] >> (30 - 2 * k)) & 32'd3);
                for (int s = 0; s < sps; s++) begin
                    exp_data.push_back(ref_iq(d, a));
                    exp_last.push_back((w == words.size() - 1) && (k == 15) && (s == sps - 1));
                end
            end
        end
    endtask

    // Drives the words queue and collects handshaked samples until 'target' are seen.
    task automatic drive(input int ready_pct, input int gap, input int target,
                         input int amp_sw_at, input logic [15:0] amp_new, input int budget);
        int idx = 0;
        int cyc = 0;
        int since_acc = 0;
        bit stalled_prev = 0;
        logic [31:0] held_d = 32'd0;
        logic held_l = 1'b0;
        got_data.delete();
        got_last.delete();
        acc_cyc = -1;
        first_vld_cyc = -1;
        last_hs_cyc = -1;
        stall_err = 0;
        timed_out = 0;
        while (got_data.size() < target) begin
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
            m_tready = ($urandom_range(99) < ready_pct);
            if (amp_sw_at >= 0 && got_data.size() >= amp_sw_at) amp = amp_new;
            if (idx < words.size() && (idx == 0 || since_acc >= gap)) begin
                s_tvalid = 1'b1;
                s_tdata  = words[idx];
                s_tlast  = (idx == words.size() - 1);
            end else begin
                s_tvalid = 1'b0;
            end
            #1;
            if (stalled_prev && (!obs_valid || obs_data !== held_d || obs_last !== held_l))
                stall_err++;
            if (obs_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (obs_valid && m_tready) begin
                got_data.push_back(obs_data);
                got_last.push_back(obs_last);
                last_hs_cyc = cyc;
            end
            stalled_prev = obs_valid && !m_tready;
            held_d = obs_data;
            held_l = obs_last;
            if (s_tvalid && obs_s_tready) begin
                if (idx == 0) acc_cyc = cyc;
                idx++;
                since_acc = 0;
            end else begin
                since_acc++;
            end
            cyc++;
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_tests++;
            if (obs_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_tvalid dut%0d: got %b want 0", s, obs_valid);
            end
            n_tests++;
            if (obs_last !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_tlast dut%0d: got %b want 0", s, obs_last);
            end
            n_tests++;
            if (obs_data !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_tdata dut%0d: got %h want 0", s, obs_data);
            end
            n_tests++;
            if (obs_s_tready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_tready dut%0d: got %b want 1", s, obs_s_tready);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sel = 1'b0;
        @(negedge clk);
    endtask

    // Compares collected samples to the model; stops at the first mismatch.
    task automatic check_seq(input string name);
        n_tests++;
        if (timed_out || got_data.size() != exp_data.size()) begin
            n_fail++;
            $display("FAIL %s_len: got %0d samples (timeout=%0d) want %0d",
                     name, got_data.size(), timed_out, exp_data.size());
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            n_tests++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL %s_sample[%0d]: got %h/%b want %h/%b",
                         name, i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
                break;
            end
        end
    endtask

    task automatic test_no_preamble;
        logic [31:0] want[5];
        want = '{32'h2D412D41, 32'h2D41D2BF, 32'hD2BF2D41, 32'hD2BFD2BF, 32'h2D412D41};
        sel = 1'b1;
        amp = 16'h2D41;
        words = '{32'h1B000000};
        build_exp(32'h2D41, 0, 16);
        drive(100, 0, 256, -1, 16'h0, 600);
        check_seq("nopre");
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (got_data.size() <= 16 * k || got_data[16 * k] !== want[k]) begin
                n_fail++;
                $display("FAIL nopre_sym%0d: got %h want %h", k,
                         (got_data.size() > 16 * k) ? got_data[16 * k] : 32'hx, want[k]);
            end
        end
        n_tests++;
        if (first_vld_cyc - acc_cyc != 2) begin
            n_fail++;
            $display("FAIL nopre_latency: got %0d cycles want 2", first_vld_cyc - acc_cyc);
        end
        sel = 1'b0;
    endtask

    task automatic test_preamble;
        sel = 1'b0;
        amp = 16'h2D41;
        words = '{$urandom()};
        build_exp(32'h2D41, 2, 4);
        drive(100, 0, 72, -1, 16'h0, 300);
        check_seq("pre");
        n_tests++;
        if (got_data.size() < 8 || got_data[0] !== 32'h2D412D41 || got_data[4] !== 32'hD2BFD2BF) begin
            n_fail++;
            $display("FAIL pre_corners: got %h,%h want 2d412d41,d2bfd2bf",
                     (got_data.size() > 0) ? got_data[0] : 32'hx,
                     (got_data.size() > 4) ? got_data[4] : 32'hx);
        end
        n_tests++;
        if (first_vld_cyc - acc_cyc != 2) begin
            n_fail++;
            $display("FAIL pre_latency: got %0d cycles want 2", first_vld_cyc - acc_cyc);
        end
    endtask

    task automatic test_back_to_back;
        int span;
        sel = 1'b0;
        amp = 16'(32'h2D41);
        words = '{$urandom(), $urandom()};
        build_exp(32'h2D41, 2, 4);
        drive(100, 0, 136, -1, 16'h0, 500);
        check_seq("b2b");
        span = last_hs_cyc - first_vld_cyc + 1;
        n_tests++;
        if (span != 136) begin
            n_fail++;
            $display("FAIL b2b_contiguous: got span %0d want 136", span);
        end
    endtask

    task automatic test_random_ready;
        int a;
        sel = 1'b0;
        a = $urandom_range(32767);
        amp = 16'(a);
        words = '{$urandom(), $urandom(), $urandom()};
        build_exp(a, 2, 4);
        drive(50, 0, 200, -1, 16'h0, 3000);
        check_seq("rready");
        n_tests++;
        if (stall_err != 0) begin
            n_fail++;
            $display("FAIL rready_stable: got %0d unstable stalls want 0", stall_err);
        end
    endtask

    task automatic test_underrun;
        int span;
        sel = 1'b0;
        amp = 16'h2D41;
        words = '{$urandom(), $urandom()};
        build_exp(32'h2D41, 2, 4);
        drive(100, 100, 136, -1, 16'h0, 800);
        check_seq("underrun");
        span = last_hs_cyc - first_vld_cyc + 1;
        n_tests++;
        if (span <= 136) begin
            n_fail++;
            $display("FAIL underrun_stall: got span %0d want >136", span);
        end
    endtask

    task automatic test_amp_change;
        sel = 1'b0;
        amp = 16'h2D41;
        words = '{$urandom()};
        build_exp(32'h2D41, 2, 4);
        drive(100, 0, 72, 20, 16'h1000, 300);
        check_seq("amp_cur");
        words = '{$urandom()};
        build_exp(32'h1000, 2, 4);
        drive(100, 0, 72, -1, 16'h0, 300);
        check_seq("amp_next");
        n_tests++;
        if (got_data.size() < 8 || got_data[0] !== 32'h10001000 || got_data[4] !== 32'hF000F000) begin
            n_fail++;
            $display("FAIL amp_next_corners: got %h,%h want 10001000,f000f000",
                     (got_data.size() > 0) ? got_data[0] : 32'hx,
                     (got_data.size() > 4) ? got_data[4] : 32'hx);
        end
    endtask

    task automatic test_reset_mid;
        sel = 1'b0;
        amp = 16'h2D41;
        words = '{$urandom(), $urandom()};
        drive(100, 0, 30, -1, 16'h0, 200);
        s_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs_valid !== 1'b0 || obs_s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got tvalid=%b tready=%b want 0/1", obs_valid, obs_s_tready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        words = '{$urandom()};
        build_exp(32'h2D41, 2, 4);
        drive(100, 0, 72, -1, 16'h0, 300);
        check_seq("rstmid_restart");
    endtask

    task automatic test_clear_mid;
        int stray = 0;
        sel = 1'b0;
        amp = 16'h2D41;
        words = '{$urandom(), $urandom()};
        drive(100, 0, 40, -1, 16'h0, 200);
        m_tready = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (obs_valid !== 1'b0 || obs_s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_outputs: got tvalid=%b tready=%b want 0/1", obs_valid, obs_s_tready);
        end
        clear = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (obs_valid) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL clear_drop_word: got %0d valid cycles want 0", stray);
        end
        words = '{$urandom()};
        build_exp(32'h2D41, 2, 4);
        drive(100, 0, 72, -1, 16'h0, 300);
        check_seq("clear_restart");
    endtask

    initial begin
        test_reset();
        test_no_preamble();
        test_preamble();
        test_back_to_back();
        test_random_ready();
        test_underrun();
        test_amp_change();
        test_reset_mid();
        test_clear_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
